// File: rtl/mem_responder.sv
// mem_responder: data memory for a small core, with an image loader in front of it.
// After reset the memory is zeroed one word per cycle (CLEAR). Loader beats are
// then accepted in order from word 0 (LOAD). Once the image is complete the core
// is released from reset and served reads and aligned word writes (RUN).
module mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           Addr_DMEM,
    input  logic [DATA_WIDTH-1:0] Rs2,
    input  logic                  MemRW,
    output logic [DATA_WIDTH-1:0] Mem,
    input  logic                  Ld_Valid,
    input  logic [DATA_WIDTH-1:0] Ld_Data,
    input  logic                  Ld_Last,
    output logic                  Ld_Ready,
    output logic [AW:0]           Ld_Count,
    output logic                  Core_Rst_n,
    output logic [1:0]            Mem_Err
);

    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         clr_cnt_q;
    logic [AW:0]           ld_count_q;
    logic                  core_rst_n_q;
    logic [1:0]            mem_err_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         addr_idx;
    logic                  addr_in_range;
    logic                  addr_aligned;
    logic                  ld_fire;
    logic                  run_wr;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Byte address -> word index; anything with bits set above the array is out of range.
    assign addr_idx      = Addr_DMEM[AW+1:2];
    assign addr_in_range = (Addr_DMEM >> (AW + 2)) == 32'd0;
    assign addr_aligned  = (Addr_DMEM[1:0] == 2'b00);

    assign Ld_Count   = ld_count_q;
    assign Core_Rst_n = core_rst_n_q;
    assign Mem_Err    = mem_err_q;

    // FSM state register.
    // NOTE: clocked state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, loader handshake, read data and the single memory write port.
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        Ld_Ready  = 1'b0;
        Mem       = '0;
        ld_fire   = 1'b0;
        run_wr    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        unique case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                Ld_Ready  = 1'b1;
                ld_fire   = Ld_Valid;
                mem_we    = Ld_Valid;
                mem_waddr = ld_count_q[AW-1:0];
                mem_wdata = Ld_Data;
                if (Ld_Valid && (Ld_Last || ld_count_q[AW-1:0] == AW'(DEPTH - 1))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (addr_in_range) begin
                    Mem = mem_q[addr_idx];
                end
                run_wr    = MemRW;
                mem_we    = MemRW && addr_in_range && addr_aligned;
                mem_waddr = addr_idx;
                mem_wdata = Rs2;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Clear/load counters, core reset release and sticky write-error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt_q    <= '0;
            ld_count_q   <= '0;
            core_rst_n_q <= 1'b0;
            mem_err_q    <= 2'b00;
        end else begin
            if (state_q == CLEAR) begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
            if (ld_fire) begin
                ld_count_q <= ld_count_q + 1'b1;
            end
            if (state_q == RUN) begin
                core_rst_n_q <= 1'b1;
            end
            if (run_wr) begin
                mem_err_q <= mem_err_q | {~addr_in_range, ~addr_aligned};
            end
        end
    end

    // Storage array write port.
    // NOTE: the array has no reset; CLEAR zeroes it word by word so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed sequence with randomized data,
// gaps and run-time traffic, checked against a word-array model of the memory.
module tb_mem_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic [31:0]   Addr_DMEM;
    logic [DW-1:0] Rs2;
    logic          MemRW;
    logic [DW-1:0] Mem;
    logic          Ld_Valid;
    logic [DW-1:0] Ld_Data;
    logic          Ld_Last;
    logic          Ld_Ready;
    logic [AW:0]   Ld_Count;
    logic          Core_Rst_n;
    logic [1:0]    Mem_Err;

    mem_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .Addr_DMEM  (Addr_DMEM),
        .Rs2        (Rs2),
        .MemRW      (MemRW),
        .Mem        (Mem),
        .Ld_Valid   (Ld_Valid),
        .Ld_Data    (Ld_Data),
        .Ld_Last    (Ld_Last),
        .Ld_Ready   (Ld_Ready),
        .Ld_Count   (Ld_Count),
        .Core_Rst_n (Core_Rst_n),
        .Mem_Err    (Mem_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory contents, words loaded so far, sticky error flags.
    logic [DW-1:0] ref_mem [DEPTH];
    int            exp_cnt;
    logic [1:0]    exp_err;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        return addr < 32'(4 * DEPTH);
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [31:0] addr);
        if (in_range(addr)) return ref_mem[int'(addr >> 2)];
        return '0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_cnt = 0;
        exp_err = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, Ld_Ready, 0);
        check({tag, "_count"}, Ld_Count, 0);
        check({tag, "_core_rst_n"}, Core_Rst_n, 0);
        check({tag, "_err"}, Mem_Err, 0);
        check({tag, "_mem"}, Mem, 0);
    endtask

    // Counts edges from reset release until Ld_Ready; Mem and Core_Rst_n stay 0 meanwhile.
    task automatic wait_clear(input bit noisy);
        int  n = 0;
        bit  done = 0;
        while (!done && n < 2 * DEPTH + 16) begin
            if (noisy) begin
                Ld_Valid = 1'($urandom_range(0, 1));
                Ld_Data  = $urandom;
                Ld_Last  = 1'($urandom_range(0, 1));
                MemRW    = 1'($urandom_range(0, 1));
            end
            Rs2       = $urandom;
            Addr_DMEM = 32'($urandom_range(0, 4 * DEPTH - 1));
            #1;
            check("clear_ready_low", Ld_Ready, 0);
            check("clear_mem_zero", Mem, 0);
            check("clear_core_rst_n", Core_Rst_n, 0);
            tick();
            n++;
            if (Ld_Ready) done = 1;
        end
        check("clear_length", n, DEPTH);
        Ld_Valid = 1'b0;
        Ld_Last  = 1'b0;
        MemRW    = 1'b0;
        check("clear_count", Ld_Count, 0);
        check("clear_err", Mem_Err, 0);
    endtask

    task automatic load_beat(input logic [DW-1:0] data, input logic last);
        Ld_Valid  = 1'b1;
        Ld_Data   = data;
        Ld_Last   = last;
        MemRW     = 1'($urandom_range(0, 1));
        Rs2       = $urandom;
        Addr_DMEM = 32'($urandom_range(0, 4 * DEPTH - 1));
        #1;
        check("load_ready", Ld_Ready, 1);
        check("load_mem_zero", Mem, 0);
        tick();
        ref_mem[exp_cnt] = data;
        exp_cnt++;
        Ld_Valid = 1'b0;
        Ld_Last  = 1'b0;
        MemRW    = 1'b0;
        check("load_count", Ld_Count, exp_cnt);
        if (last || exp_cnt == DEPTH) begin
            check("run_entry_ready", Ld_Ready, 0);
            check("run_entry_core_rst_n", Core_Rst_n, 0);
            tick();
            check("run_core_rst_n_release", Core_Rst_n, 1);
            check("run_entry_err", Mem_Err, 0);
        end else begin
            check("load_core_rst_n", Core_Rst_n, 0);
        end
    endtask

    task automatic load_gap();
        Ld_Valid = 1'b0;
        Ld_Data  = $urandom;
        Ld_Last  = 1'($urandom_range(0, 1));
        tick();
        Ld_Last = 1'b0;
        check("gap_count", Ld_Count, exp_cnt);
        check("gap_ready", Ld_Ready, 1);
    endtask

    // One RUN cycle: read value before the edge, model update, then error flags and read after.
    task automatic run_op(input logic [31:0] addr, input logic wr, input logic [DW-1:0] data);
        Addr_DMEM = addr;
        MemRW     = wr;
        Rs2       = data;
        Ld_Valid  = 1'($urandom_range(0, 1));
        Ld_Data   = $urandom;
        Ld_Last   = 1'($urandom_range(0, 1));
        #1;
        check("run_read_before", Mem, model_read(addr));
        check("run_ready_low", Ld_Ready, 0);
        tick();
        if (wr) begin
            if (addr[1:0] != 2'b00) exp_err[0] = 1'b1;
            if (!in_range(addr)) exp_err[1] = 1'b1;
            if (addr[1:0] == 2'b00 && in_range(addr)) ref_mem[int'(addr >> 2)] = data;
        end
        check("run_err", Mem_Err, exp_err);
        check("run_read_after", Mem, model_read(addr));
        check("run_count", Ld_Count, exp_cnt);
        MemRW    = 1'b0;
        Ld_Valid = 1'b0;
        Ld_Last  = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = $urandom;
            1:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 15) * 4);
            2:       a = 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'd1;
            3:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 63)) | 32'd2;
            default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        endcase
        return a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        rst       = 1'b1;
        Ld_Valid  = 1'b0;
        Ld_Data   = '0;
        Ld_Last   = 1'b0;
        MemRW     = 1'b0;
        Addr_DMEM = 32'h4;
        Rs2       = '0;
        clear_model();

        // Power-on reset, then the clear sweep with a quiet loader.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        wait_clear(0);

        // Three-beat image with a one-cycle gap.
        load_beat(32'h11, 1'b0);
        load_gap();
        load_beat(32'h22, 1'b0);
        load_beat(32'h33, 1'b1);
        check("img3_count", Ld_Count, 3);
        run_op(32'h4, 1'b0, '0);
        run_op(32'hC, 1'b0, '0);

        // Aligned, misaligned and out-of-range writes.
        run_op(32'h10, 1'b1, 32'hDEADBEEF);
        run_op(32'h12, 1'b1, 32'hDEADBEEF);
        run_op(32'h400, 1'b1, 32'hDEADBEEF);
        check("err_both_set", Mem_Err, 2'b11);
        run_op(32'h10, 1'b0, '0);
        run_op(32'h400, 1'b0, '0);

        // Same-cycle write and read of word 2 (holds 0x33).
        run_op(32'h8, 1'b1, 32'h55);
        run_op(32'h2C, 1'b0, '0);
        check("err_sticky", Mem_Err, 2'b11);

        // Reset out of RUN; clear again with a noisy loader and core.
        rst       = 1'b1;
        Addr_DMEM = 32'h8;
        #1;
        check_reset_outputs("run_rst");
        tick();
        rst = 1'b0;
        clear_model();
        wait_clear(1);

        // Reset in the middle of a load; nothing of the partial image survives.
        load_beat($urandom | 32'h1, 1'b0);
        load_beat($urandom | 32'h1, 1'b0);
        rst       = 1'b1;
        Addr_DMEM = 32'h0;
        #1;
        check_reset_outputs("midload_rst");
        tick();
        tick();
        check_reset_outputs("midload_hold");
        rst = 1'b0;
        clear_model();
        wait_clear(0);
        d = $urandom;
        load_beat(d, 1'b1);
        run_op(32'h0, 1'b0, '0);
        run_op(32'h4, 1'b0, '0);

        // Full image with no Ld_Last and random gaps.
        rst = 1'b1;
        #1;
        check_reset_outputs("full_rst");
        tick();
        rst = 1'b0;
        clear_model();
        wait_clear(1);
        while (exp_cnt < DEPTH) begin
            if ($urandom_range(0, 3) == 0) load_gap();
            load_beat($urandom, 1'b0);
        end
        check("full_count", Ld_Count, DEPTH);
        for (int i = 0; i < 4; i++) begin
            Ld_Valid = 1'b1;
            Ld_Data  = $urandom;
            Ld_Last  = 1'($urandom_range(0, 1));
            tick();
            check("late_beat_count", Ld_Count, DEPTH);
            check("late_beat_ready", Ld_Ready, 0);
        end
        Ld_Valid = 1'b0;
        Ld_Last  = 1'b0;
        run_op(32'h3FC, 1'b0, '0);
        run_op(32'h0, 1'b0, '0);

        // Random core traffic against the model.
        for (int i = 0; i < 150; i++) begin
            run_op(rand_addr(), 1'($urandom_range(0, 1)), $urandom);
        end
        for (int i = 0; i < 16; i++) begin
            run_op(32'($urandom_range(0, DEPTH - 1)) << 2, 1'b0, '0);
        end
        check("final_core_rst_n", Core_Rst_n, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 256, storage in words; a power of two and at least 4; AW = log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset: one clock; reset is asynchronous and active-high.
REQ-005 Addr_DMEM  input  32  byte address from the core memory stage.
REQ-006 Rs2  input  DATA_WIDTH  store data from the core.
REQ-007 MemRW  input  1  1 = write, 0 = read.
REQ-008 Mem  output  DATA_WIDTH  read data returned to the core.
REQ-009 Ld_Valid  input  1  loader beat valid.
REQ-010 Ld_Data  input  DATA_WIDTH  loader word.
REQ-011 Ld_Last  input  1  marks the final loader beat.
REQ-012 Ld_Ready  output  1  responder accepts a loader beat.
REQ-013 Ld_Count  output  AW+1  number of words loaded.
REQ-014 Core_Rst_n  output  1  active-low reset to the core; held low until the image is loaded.
REQ-015 Mem_Err  output  2  sticky flags: bit1 = range error, bit0 = misalignment error.

Function
REQ-016 FSM states: CLEAR, LOAD, RUN; no other reachable state.
REQ-017 CLEAR: a clear counter zeroes one word per cycle, indices 0..DEPTH-1; after index DEPTH-1 is written the FSM enters LOAD, so CLEAR lasts exactly DEPTH cycles.
REQ-018 LOAD: Ld_Ready = 1; a beat transfers on a rising edge with Ld_Valid & Ld_Ready, writing Ld_Data to word Ld_Count[AW-1:0] and incrementing Ld_Count.
REQ-019 LOAD -> RUN after the beat that carries Ld_Last = 1, or after the beat written to word DEPTH-1, whichever comes first; Ld_Count then holds the total beats accepted (DEPTH maximum).
REQ-020 Ld_Ready = 0 in CLEAR and RUN; Ld_Valid, Ld_Data and Ld_Last are ignored outside LOAD.
REQ-021 Core_Rst_n is registered: 0 in CLEAR and LOAD; it rises on the first rising edge after RUN is entered and stays 1 until rst.
REQ-022 Word index = Addr_DMEM[AW+1:2]; an address is in range when Addr_DMEM < 4*DEPTH and aligned when Addr_DMEM[1:0] = 0.
REQ-023 RUN read: Mem is combinational, equal to the stored word at the index when in range, else 0; Addr_DMEM[1:0] are ignored for reads.
REQ-024 Mem = 0 in CLEAR and LOAD regardless of the address.
REQ-025 RUN write: with MemRW = 1, an aligned, in-range address stores Rs2 on the rising edge; there are no byte or halfword strobes.
REQ-026 A write with Addr_DMEM[1:0] != 0 is dropped and sets Mem_Err[0]; an out-of-range write is dropped and sets Mem_Err[1]; both may be set in the same cycle.
REQ-027 Reads never set Mem_Err; MemRW is ignored outside RUN.
REQ-028 Reading and writing the same word in one cycle returns the old value on Mem until the edge and the new value afterwards.
REQ-029 Mem_Err bits are sticky until rst.

Reset
REQ-030 While rst = 1: FSM = CLEAR, clear counter = 0, Ld_Count = 0, Ld_Ready = 0, Core_Rst_n = 0, Mem_Err = 0, Mem = 0.
REQ-031 rst asserted in any state, including mid-load or mid-run, aborts the operation, and memory is fully re-cleared before LOAD is re-entered.

Verification
REQ-032 Release rst, Ld_Valid = 0 -> Ld_Ready rises after exactly DEPTH cycles (256); Core_Rst_n = 0; Mem = 0 throughout.
REQ-033 Load 3 beats 0x11,0x22,0x33 (Ld_Last on the third), with a one-cycle Ld_Valid gap -> Ld_Count = 3; Core_Rst_n = 1 one edge after RUN is entered; reading 0x4 returns 0x22, and 0xC returns 0.
REQ-034 Load DEPTH beats with no Ld_Last -> RUN entered after beat 256; Ld_Count = 256; later Ld_Valid beats are ignored.
REQ-035 In RUN: write 0xDEADBEEF to 0x10, then to 0x12 (misaligned), then to 0x400 (out of range) -> 0x10 reads 0xDEADBEEF; Mem_Err = 2'b11; a read at 0x400 returns 0.
REQ-036 In RUN, same-cycle write/read at 0x8 with old value 0x33 and Rs2 = 0x55 -> Mem = 0x33 before the edge and 0x55 after.
REQ-037 Assert rst mid-LOAD after 2 beats -> all outputs return to their reset values; after the next CLEAR, a read of 0x0 in the subsequent RUN returns 0 unless reloaded.
